// File: rtl/fetch_stage.sv
// Purpose : instruction fetch - owns the PC, reads a 1-cycle synchronous imem, registers IF/ID.
// Latency : a word fetched in cycle N is visible on o_inst from cycle N+2 (redirect target: 2 bubbles).
// Backpr. : i_stall holds IF/ID and fetch_pc; the one in-flight word parks in a 1-entry skid.
//
// Ports:
//   i_clk, i_rst                 clock (rising edge), asynchronous active-high reset
//   o_imem_raddr, o_imem_ren     fetch request; word returns on i_imem_rdata next cycle
//   i_imem_rdata                 instruction word for the request issued last cycle
//   i_stall                      downstream stall
//   i_redirect, i_redirect_pc    taken branch/jump: flush and refetch from target
//   o_inst, o_inst_pc,
//   o_inst_valid                 IF/ID register (o_inst = NOP_INST when not valid)
//   o_halt                       ebreak retired from IF/ID (sticky)
//   o_misaligned                 redirect target not word aligned (sticky)
//   o_fetch_count,
//   o_bubble_count               only with `define FETCH_PERF_EN: valid / bubble load counters
module fetch_stage #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_imem_raddr,
  output logic        o_imem_ren,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_inst_valid,
  output logic        o_halt,
  output logic        o_misaligned
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] o_fetch_count,
  output logic [31:0] o_bubble_count
`endif
);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_HALT_PEND = 2'd1;
  localparam logic [1:0] ST_HALT      = 2'd2;
  localparam logic [1:0] ST_FAULT     = 2'd3;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        halt_q, halt_d;
  logic        misaligned_q, misaligned_d;
  logic        ren;

  // A stall never issues, so at most one response can be outstanding and
  // the single skid entry always has room.
  assign ren = (state_q == ST_RUN) && !i_stall && !i_redirect;

  assign o_imem_ren   = ren;
  assign o_imem_raddr = fetch_pc_q;
  assign o_inst       = inst_q;
  assign o_inst_pc    = inst_pc_q;
  assign o_inst_valid = inst_valid_q;
  assign o_halt       = halt_q;
  assign o_misaligned = misaligned_q;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_valid_d  = ren;
    req_pc_d     = req_pc_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    halt_d       = halt_q;
    misaligned_d = misaligned_q;

    if (ren) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    case (state_q)
      ST_RUN, ST_HALT_PEND: begin
        if (i_redirect) begin
          // Redirect wins over stall; anything fetched so far is wrong-path.
          inst_d       = NOP_INST;
          inst_valid_d = 1'b0;
          skid_valid_d = 1'b0;
          fetch_pc_d   = i_redirect_pc;
          if (i_redirect_pc[1:0] != 2'b00) begin
            state_d      = ST_FAULT;
            misaligned_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else if (state_q == ST_HALT_PEND) begin
          // Nothing behind the ebreak may enter IF/ID.
          skid_valid_d = 1'b0;
          if (!i_stall) begin
            inst_d       = NOP_INST;
            inst_valid_d = 1'b0;
            state_d      = ST_HALT;
            halt_d       = 1'b1;
          end
        end else if (i_stall) begin
          if (req_valid_q) begin
            skid_valid_d = 1'b1;
            skid_inst_d  = i_imem_rdata;
            skid_pc_d    = req_pc_q;
          end
        end else begin
          if (skid_valid_q) begin
            inst_d       = skid_inst_q;
            inst_pc_d    = skid_pc_q;
            inst_valid_d = 1'b1;
            skid_valid_d = 1'b0;
          end else if (req_valid_q) begin
            inst_d       = i_imem_rdata;
            inst_pc_d    = req_pc_q;
            inst_valid_d = 1'b1;
          end else begin
            inst_d       = NOP_INST;
            inst_valid_d = 1'b0;
          end
          if (inst_valid_d && (inst_d == EBREAK_INST)) begin
            state_d = ST_HALT_PEND;
          end
        end
      end
      default: ; // HALT and FAULT are terminal until reset
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_RUN;
      fetch_pc_q   <= RESET_ADDR;
      req_valid_q  <= 1'b0;
      req_pc_q     <= 32'd0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= 32'd0;
      skid_pc_q    <= 32'd0;
      inst_q       <= NOP_INST;
      inst_pc_q    <= 32'd0;
      inst_valid_q <= 1'b0;
      halt_q       <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_valid_q  <= req_valid_d;
      req_pc_q     <= req_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      halt_q       <= halt_d;
      misaligned_q <= misaligned_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] bubble_count_q, bubble_count_d;
  logic        ifid_load;

  // IF/ID is written whenever a live state is not held by a stall (redirect overrides stall).
  assign ifid_load = ((state_q == ST_RUN) || (state_q == ST_HALT_PEND)) && (i_redirect || !i_stall);

  always_comb begin
    fetch_count_d  = fetch_count_q;
    bubble_count_d = bubble_count_q;
    if (ifid_load && inst_valid_d) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
    if (ifid_load && !inst_valid_d && (state_q == ST_RUN) && !i_stall) begin
      bubble_count_d = bubble_count_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_count_q  <= 32'd0;
      bubble_count_q <= 32'd0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign o_fetch_count  = fetch_count_q;
  assign o_bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic        L0     = 1'b0;
  localparam logic        L1     = 1'b1;

  logic        clk, rst;
  logic [31:0] imem_raddr, imem_rdata, redirect_pc, inst, inst_pc;
  logic        imem_ren, stall, redirect, inst_valid, halt, misaligned;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, bubble_count;
`endif

  int n_vec = 0;
  int n_bad = 0;

  fetch_stage #(.RESET_ADDR(32'h0000_0000), .NOP_INST(NOP)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_imem_raddr (imem_raddr),
    .o_imem_ren   (imem_ren),
    .i_imem_rdata (imem_rdata),
    .i_stall      (stall),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .o_inst       (inst),
    .o_inst_pc    (inst_pc),
    .o_inst_valid (inst_valid),
    .o_halt       (halt),
    .o_misaligned (misaligned)
`ifdef FETCH_PERF_EN
    ,
    .o_fetch_count (fetch_count),
    .o_bubble_count(bubble_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: each word holds its own address, except one optional ebreak slot.
  logic        ebreak_en;
  logic [31:0] ebreak_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ebreak_en && (a == ebreak_addr)) return EBREAK;
    return a;
  endfunction

  always @(posedge clk) if (imem_ren) imem_rdata <= mem_word(imem_raddr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %08h expected %08h", name, $time, act, exp);
    end
  endtask

  // IF/ID check for the address-as-data memory.
  task automatic chk_if(input string name, input logic vld, input logic [31:0] pc);
    chk({name, " valid"}, 32'(inst_valid), 32'(vld));
    if (vld) begin
      chk({name, " pc"}, inst_pc, pc);
      chk({name, " inst"}, inst, pc);
    end else begin
      chk({name, " inst"}, inst, NOP);
    end
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] rpc);
    @(negedge clk);
    rst = 1'b0; stall = s; redirect = r; redirect_pc = rpc;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    @(posedge clk);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        s;
    logic        r;
    logic [31:0] rpc;
    logic        ren;
    logic [31:0] raddr;
    logic        vld;
    logic [31:0] pc;
    logic        mis;
  } vec_t;

  vec_t tbl[17];

  // ---------------- reference model ----------------
  // The fetch stream is a queue of PCs already requested; an unstalled cycle
  // moves the oldest one into IF/ID, otherwise IF/ID takes a bubble.
  typedef enum int {M_RUN, M_HPEND, M_HALT, M_FAULT} mst_t;
  mst_t        m_st;
  logic [31:0] m_q[$];
  logic [31:0] m_fpc, m_inst, m_pc, m_fc, m_bc;
  logic        m_vld, m_halt, m_mis;

  task automatic model_reset();
    m_st = M_RUN; m_q.delete(); m_fpc = 32'h0; m_inst = NOP; m_pc = 32'h0;
    m_vld = 1'b0; m_halt = 1'b0; m_mis = 1'b0; m_fc = 32'h0; m_bc = 32'h0;
  endtask

  task automatic model_edge();
    logic        issue;
    logic [31:0] pc;
    issue = (m_st == M_RUN) && !stall && !redirect;
    if ((m_st == M_RUN || m_st == M_HPEND) && redirect) begin
      if (m_st == M_RUN && !stall) m_bc = m_bc + 32'd1;
      m_q.delete(); m_vld = 1'b0; m_inst = NOP; m_fpc = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        m_st = M_FAULT; m_mis = 1'b1;
      end else begin
        m_st = M_RUN;
      end
    end else if (m_st == M_HPEND) begin
      m_q.delete();
      if (!stall) begin
        m_vld = 1'b0; m_inst = NOP; m_st = M_HALT; m_halt = 1'b1;
      end
    end else if (m_st == M_RUN) begin
      if (!stall) begin
        if (m_q.size() > 0) begin
          pc = m_q.pop_front();
          m_vld = 1'b1; m_pc = pc; m_inst = mem_word(pc); m_fc = m_fc + 32'd1;
          if (m_inst == EBREAK) m_st = M_HPEND;
        end else begin
          m_vld = 1'b0; m_inst = NOP; m_bc = m_bc + 32'd1;
        end
      end
      if (issue) begin
        m_q.push_back(m_fpc);
        m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  task automatic model_check();
    logic exp_ren;
    chk("rnd valid", 32'(inst_valid), 32'(m_vld));
    chk("rnd inst", inst, m_inst);
    if (m_vld) chk("rnd pc", inst_pc, m_pc);
    chk("rnd halt", 32'(halt), 32'(m_halt));
    chk("rnd misaligned", 32'(misaligned), 32'(m_mis));
    if (!rst) begin
      exp_ren = (m_st == M_RUN) && !stall && !redirect;
      chk("rnd ren", 32'(imem_ren), 32'(exp_ren));
      if (exp_ren) chk("rnd raddr", imem_raddr, m_fpc);
    end
  endtask

  initial begin
    logic do_r;
    int   sel;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    ebreak_en = 1'b0; ebreak_addr = 32'h0;

    // Fill-up, 3-cycle stall at 0x8, redirect to 0x100 at 0x14, misaligned redirect.
    tbl[0]  = '{L0, L0, 32'h0,   L1, 32'h0,   L0, 32'h0,   L0};
    tbl[1]  = '{L0, L0, 32'h0,   L1, 32'h4,   L0, 32'h0,   L0};
    tbl[2]  = '{L0, L0, 32'h0,   L1, 32'h8,   L1, 32'h0,   L0};
    tbl[3]  = '{L0, L0, 32'h0,   L1, 32'hC,   L1, 32'h4,   L0};
    tbl[4]  = '{L1, L0, 32'h0,   L0, 32'h0,   L1, 32'h8,   L0};
    tbl[5]  = '{L1, L0, 32'h0,   L0, 32'h0,   L1, 32'h8,   L0};
    tbl[6]  = '{L1, L0, 32'h0,   L0, 32'h0,   L1, 32'h8,   L0};
    tbl[7]  = '{L0, L0, 32'h0,   L1, 32'h10,  L1, 32'h8,   L0};
    tbl[8]  = '{L0, L0, 32'h0,   L1, 32'h14,  L1, 32'hC,   L0};
    tbl[9]  = '{L0, L0, 32'h0,   L1, 32'h18,  L1, 32'h10,  L0};
    tbl[10] = '{L0, L1, 32'h100, L0, 32'h0,   L1, 32'h14,  L0};
    tbl[11] = '{L0, L0, 32'h0,   L1, 32'h100, L0, 32'h0,   L0};
    tbl[12] = '{L0, L0, 32'h0,   L1, 32'h104, L0, 32'h0,   L0};
    tbl[13] = '{L0, L0, 32'h0,   L1, 32'h108, L1, 32'h100, L0};
    tbl[14] = '{L0, L0, 32'h0,   L1, 32'h10C, L1, 32'h104, L0};
    tbl[15] = '{L0, L1, 32'h102, L0, 32'h0,   L1, 32'h108, L0};
    tbl[16] = '{L0, L0, 32'h0,   L0, 32'h0,   L0, 32'h0,   L1};

    repeat (2) @(negedge clk);
    chk_if("reset", L0, 32'h0);
    chk("reset pc", inst_pc, 32'h0);
    chk("reset halt", 32'(halt), 32'h0);
    chk("reset misaligned", 32'(misaligned), 32'h0);

    for (int k = 0; k < 17; k++) begin
      step(tbl[k].s, tbl[k].r, tbl[k].rpc);
      chk($sformatf("tbl%0d ren", k), 32'(imem_ren), 32'(tbl[k].ren));
      if (tbl[k].ren) chk($sformatf("tbl%0d raddr", k), imem_raddr, tbl[k].raddr);
      chk_if($sformatf("tbl%0d", k), tbl[k].vld, tbl[k].pc);
      chk($sformatf("tbl%0d misaligned", k), 32'(misaligned), 32'(tbl[k].mis));
    end

    // FAULT ignores everything until reset.
    for (int k = 0; k < 20; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      chk("fault ren", 32'(imem_ren), 32'h0);
      chk("fault valid", 32'(inst_valid), 32'h0);
      chk("fault misaligned", 32'(misaligned), 32'h1);
    end

    // ebreak at 0x10 halts once it leaves IF/ID.
    ebreak_en = 1'b1; ebreak_addr = 32'h10;
    do_reset();
    repeat (6) step(L0, L0, 32'h0);
    step(L0, L0, 32'h0);
    chk("ebk valid", 32'(inst_valid), 32'h1);
    chk("ebk inst", inst, EBREAK);
    chk("ebk pc", inst_pc, 32'h10);
    chk("ebk pend ren", 32'(imem_ren), 32'h0);
    chk("ebk pend halt", 32'(halt), 32'h0);
    step(L0, L0, 32'h0);
    chk("ebk halt", 32'(halt), 32'h1);
    chk("ebk halt valid", 32'(inst_valid), 32'h0);
    for (int k = 0; k < 8; k++) begin
      step(1'($urandom_range(0, 1)), L1, 32'h40);
      chk("halted ren", 32'(imem_ren), 32'h0);
      chk("halted halt", 32'(halt), 32'h1);
      chk("halted valid", 32'(inst_valid), 32'h0);
    end

    // Same, but a redirect during HALT_PEND cancels the halt.
    do_reset();
    repeat (6) step(L0, L0, 32'h0);
    step(L0, L1, 32'h40);
    chk("ebk2 inst", inst, EBREAK);
    chk("ebk2 ren", 32'(imem_ren), 32'h0);
    step(L0, L0, 32'h0);
    chk_if("ebk2 c7", L0, 32'h0);
    chk("ebk2 raddr", imem_raddr, 32'h40);
    chk("ebk2 ren c7", 32'(imem_ren), 32'h1);
    step(L0, L0, 32'h0);
    chk_if("ebk2 c8", L0, 32'h0);
    step(L0, L0, 32'h0);
    chk_if("ebk2 c9", L1, 32'h40);
    step(L0, L0, 32'h0);
    chk_if("ebk2 c10", L1, 32'h44);
    chk("ebk2 halt", 32'(halt), 32'h0);

    // Async reset while stalled with the skid full.
    ebreak_en = 1'b0;
    do_reset();
    repeat (4) step(L0, L0, 32'h0);
    step(L1, L0, 32'h0);
    step(L1, L0, 32'h0);
    chk_if("skid setup", L1, 32'h8);
    rst = 1'b1;
    #1;
    chk_if("midrst", L0, 32'h0);
    chk("midrst pc", inst_pc, 32'h0);
    chk("midrst halt", 32'(halt), 32'h0);
    chk("midrst misaligned", 32'(misaligned), 32'h0);
    @(posedge clk);
    step(L0, L0, 32'h0);
    chk("post-rst ren", 32'(imem_ren), 32'h1);
    chk("post-rst raddr", imem_raddr, 32'h0);
    chk_if("post-rst c0", L0, 32'h0);
    step(L0, L0, 32'h0);
    chk_if("post-rst c1", L0, 32'h0);
    step(L0, L0, 32'h0);
    chk_if("post-rst c2", L1, 32'h0);
    step(L0, L0, 32'h0);
    chk_if("post-rst c3", L1, 32'h4);

    // Randomised run against the queue model.
    ebreak_en = 1'b1; ebreak_addr = 32'h80;
    do_reset();
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      do_r = ($urandom_range(0, 299) == 0) ||
             (((m_st == M_HALT) || (m_st == M_FAULT)) && ($urandom_range(0, 7) == 0));
      rst = do_r;
      stall = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 24) == 0);
      sel = $urandom_range(0, 15);
      if (sel == 0)
        redirect_pc = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 1)
        redirect_pc = 32'hFFFF_FFF0;
      else
        redirect_pc = 32'($urandom_range(0, 63)) << 2;
      if (do_r) model_reset();
      #1;
      model_check();
      @(posedge clk);
      if (!rst) model_edge();
    end
`ifdef FETCH_PERF_EN
    @(negedge clk);
    chk("perf fetch_count", fetch_count, m_fc);
    chk("perf bubble_count", bubble_count, m_bc);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
